// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by both the ALU decoder and
// the execute unit, the execute FSM state type, and a shift-op classifier.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLLV = 4'b1000,
        ALU_SRL  = 4'b1100,
        ALU_SRA  = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // True for the iterative (one bit per cycle) shift operations.
    function automatic logic is_shift(input alu_op_t op);
        return (op == ALU_SRL) || (op == ALU_SRA) || (op == ALU_SLLV);
    endfunction

endpackage

// File: rtl/alu_exec_unit_comb.sv
// Purely combinational single-cycle ALU operations plus the illegal-code flag.
// Shift codes are legal but handled by the iterative path in the top, so they
// produce zero here.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             illegal
);

    // Select the single-cycle result; anything undefined yields zero and flags illegal.
    always_comb begin
        y       = '0;
        illegal = 1'b0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_SLT:  y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SRL,
            ALU_SRA,
            ALU_SLLV: y = '0;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes. Single-cycle ops register
// their result one cycle after acceptance; shifts iterate one bit per cycle
// while busy asks the hazard unit to stall.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    state_t           state;
    logic             started;
    logic [WIDTH-1:0] shreg;
    logic [SHW-1:0]   cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] comb_y;
    logic             comb_illegal;
    logic             accept;
    logic [SHW-1:0]   amount;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op      (alucontrol),
        .a       (srca),
        .b       (srcb),
        .y       (comb_y),
        .illegal (comb_illegal)
    );

    // A result leaving DONE frees the unit in the same cycle, allowing back-to-back issue.
    assign in_ready = started && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept   = in_valid && in_ready;
    assign amount   = (alucontrol == ALU_SLLV) ? srca[SHW-1:0] : shamt;

    // One-bit step of the latched shift; sra replicates the sign bit.
    always_comb begin
        shift_next = shreg;
        case (op_q)
            ALU_SRL:  shift_next = {1'b0, shreg[WIDTH-1:1]};
            ALU_SRA:  shift_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
            ALU_SLLV: shift_next = {shreg[WIDTH-2:0], 1'b0};
            default:  shift_next = shreg;
        endcase
    end

    // Holds in_ready low until the first clock edge after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // Execute FSM: accept, iterate shifts, and hold the result until taken downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            shreg     <= '0;
            op_q      <= ALU_AND;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_shift(alu_op_t'(alucontrol))) begin
                            if (amount == '0) begin
                                result    <= srcb;
                                zero      <= (srcb == '0);
                                illegal   <= 1'b0;
                                out_valid <= 1'b1;
                                state     <= DONE;
                            end else begin
                                shreg     <= srcb;
                                cnt       <= amount;
                                op_q      <= alucontrol;
                                busy      <= 1'b1;
                                out_valid <= 1'b0;
                                state     <= SHIFT;
                            end
                        end else begin
                            result    <= comb_y;
                            zero      <= (comb_y == '0);
                            illegal   <= comb_illegal;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                SHIFT: begin
                    shreg <= shift_next;
                    cnt   <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        result    <= shift_next;
                        zero      <= (shift_next == '0);
                        illegal   <= 1'b0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
